// File: rtl/rv32i_fetch_pkg.sv
// Types and helpers shared by the RV32I fetch stage and its skid buffer.
package rv32i_fetch_pkg;

    typedef enum logic [1:0] {
        Fetch   = 2'd0,
        Discard = 2'd1,
        Held    = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PcStep = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32i_fetch_skid.sv
// One-entry buffer holding an instruction word and its PC that arrived while the pipe was stalled.
`include "rv32i_header.vh"

module rv32i_fetch_skid (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_data,
    input  logic [31:0] i_pc,
    output logic [31:0] o_data,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    logic [31:0] data_q;
    logic [31:0] pc_q;
    logic        valid_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= `NOP;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
        end else if (i_load) begin
            data_q  <= i_data;
            pc_q    <= i_pc;
            valid_q <= 1'b1;
        end else if (i_clear) begin
            valid_q <= 1'b0;
        end
    end

    assign o_data  = data_q;
    assign o_pc    = pc_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/rv32i_header.vh
// Shared RV32I pipeline constants: canonical NOP encoding and per-stage stall vector indices.
`ifndef RV32I_HEADER_VH
`define RV32I_HEADER_VH

`define NOP          32'h0000_0013
`define FETCH        0
`define DECODER      1
`define ALU          2
`define MEMORYACCESS 3
`define WRITEBACK    4
`define STALL_WIDTH  5

`endif

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage: single outstanding request, redirect/discard handling.
// Define FETCH_SKID_BUFFER_EN to keep a word acked during a stall instead of refetching it.
`include "rv32i_header.vh"

module rv32i_fetch
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic [31:0]             o_iaddr,
    output logic                    o_stb_inst,
    input  logic                    i_ack_inst,
    input  logic [31:0]             i_inst,
    input  logic                    i_change_pc,
    input  logic [31:0]             i_new_pc,
    input  logic                    i_flush,
    input  logic [`STALL_WIDTH-1:0] i_stall,
    output logic [31:0]             o_inst,
    output logic [31:0]             o_pc,
    output logic                    o_ce,
    output logic                    o_stall
);

    fetch_state_e state_q, state_d;
    logic [31:0]  iaddr_q, iaddr_d;
    logic         stb_q, stb_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q, pc_d;
    logic         ce_q, ce_d;
    logic [31:0]  target_q, target_d;

    logic stall_bit;
    logic ack_vld;

    assign stall_bit = i_stall[`FETCH] | i_stall[`DECODER] | i_stall[`ALU] |
                       i_stall[`MEMORYACCESS] | i_stall[`WRITEBACK];
    // An ack only counts against a live request; stray acks (e.g. across reset) are ignored.
    assign ack_vld   = stb_q & i_ack_inst;

`ifdef FETCH_SKID_BUFFER_EN
    logic        skid_load;
    logic        skid_clear;
    logic [31:0] skid_data;
    logic [31:0] skid_pc;
    logic        skid_valid;

    rv32i_fetch_skid u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (skid_load),
        .i_clear (skid_clear),
        .i_data  (i_inst),
        .i_pc    (iaddr_q),
        .o_data  (skid_data),
        .o_pc    (skid_pc),
        .o_valid (skid_valid)
    );
`endif

    always_comb begin
        state_d  = state_q;
        iaddr_d  = iaddr_q;
        stb_d    = stb_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        ce_d     = ce_q;
        target_d = target_q;
`ifdef FETCH_SKID_BUFFER_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
`endif

        case (state_q)
            Fetch: begin
                if (i_change_pc) begin
                    ce_d = 1'b0;
                    if (stb_q && !i_ack_inst) begin
                        // Address must stay put until the in-flight request completes.
                        target_d = align_pc(i_new_pc);
                        state_d  = Discard;
                    end else begin
                        iaddr_d = align_pc(i_new_pc);
                        stb_d   = 1'b1;
                    end
                end else if (i_flush) begin
                    ce_d  = 1'b0;
                    stb_d = 1'b1;
                end else if (stall_bit) begin
                    if (ack_vld) begin
`ifdef FETCH_SKID_BUFFER_EN
                        skid_load = 1'b1;
                        iaddr_d   = iaddr_q + PcStep;
                        stb_d     = 1'b0;
                        state_d   = Held;
`else
                        // Word is dropped; park the request and refetch it on release.
                        stb_d = 1'b0;
`endif
                    end
                end else if (ack_vld) begin
                    inst_d  = i_inst;
                    pc_d    = iaddr_q;
                    ce_d    = 1'b1;
                    iaddr_d = iaddr_q + PcStep;
                    stb_d   = 1'b1;
                end else begin
                    ce_d  = 1'b0;
                    stb_d = 1'b1;
                end
            end

            Discard: begin
                ce_d = 1'b0;
                if (i_change_pc) begin
                    if (ack_vld) begin
                        iaddr_d = align_pc(i_new_pc);
                        state_d = Fetch;
                    end else begin
                        target_d = align_pc(i_new_pc);
                    end
                end else if (ack_vld) begin
                    iaddr_d = target_q;
                    stb_d   = 1'b1;
                    state_d = Fetch;
                end
            end

`ifdef FETCH_SKID_BUFFER_EN
            Held: begin
                if (i_change_pc) begin
                    skid_clear = 1'b1;
                    iaddr_d    = align_pc(i_new_pc);
                    stb_d      = 1'b1;
                    ce_d       = 1'b0;
                    state_d    = Fetch;
                end else if (i_flush) begin
                    skid_clear = 1'b1;
                    ce_d       = 1'b0;
                    stb_d      = 1'b1;
                    state_d    = Fetch;
                end else if (!skid_valid) begin
                    stb_d   = 1'b1;
                    state_d = Fetch;
                end else if (!stall_bit) begin
                    inst_d     = skid_data;
                    pc_d       = skid_pc;
                    ce_d       = 1'b1;
                    skid_clear = 1'b1;
                    stb_d      = 1'b1;
                    state_d    = Fetch;
                end
            end
`endif

            default: begin
                state_d = Fetch;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= Fetch;
            iaddr_q  <= PC_RESET;
            stb_q    <= 1'b0;
            inst_q   <= `NOP;
            pc_q     <= 32'h0;
            ce_q     <= 1'b0;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            iaddr_q  <= iaddr_d;
            stb_q    <= stb_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            ce_q     <= ce_d;
            target_q <= target_d;
        end
    end

    assign o_iaddr    = iaddr_q;
    assign o_stb_inst = stb_q;
    assign o_inst     = inst_q;
    assign o_pc       = pc_q;
    assign o_ce       = ce_q;
    assign o_stall    = stall_bit;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch: streaming, stall/skid, redirects, wrap and reset in DISCARD.
module tb_rv32i_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr;
    logic        stb;
    logic        ack;
    logic [31:0] inst_in;
    logic        change_pc;
    logic [31:0] new_pc;
    logic        flush;
    logic [4:0]  stall;
    logic [31:0] inst_out;
    logic [31:0] pc;
    logic        ce;
    logic        stall_out;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    rv32i_fetch #(
        .PC_RESET (32'h0000_0000)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_iaddr     (iaddr),
        .o_stb_inst  (stb),
        .i_ack_inst  (ack),
        .i_inst      (inst_in),
        .i_change_pc (change_pc),
        .i_new_pc    (new_pc),
        .i_flush     (flush),
        .i_stall     (stall),
        .o_inst      (inst_out),
        .o_pc        (pc),
        .o_ce        (ce),
        .o_stall     (stall_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ce"},    {31'b0, ce},  32'h0);
        check_eq({tag, "_stb"},   {31'b0, stb}, 32'h0);
        check_eq({tag, "_iaddr"}, iaddr,        32'h0);
        check_eq({tag, "_pc"},    pc,           32'h0);
        check_eq({tag, "_inst"},  inst_out,     32'h0000_0013);
    endtask

    initial begin
        rst       = 1'b1;
        ack       = 1'b1;
        inst_in   = 32'h0;
        change_pc = 1'b0;
        new_pc    = 32'h0;
        flush     = 1'b0;
        stall     = 5'b0;
        step;
        step;
        check_reset_outputs("rst");

        // Ack held high across release must be ignored until a request is live.
        rst     = 1'b0;
        inst_in = 32'h0050_0093;
        step;
        check_eq("first_stb",   {31'b0, stb}, 32'h1);
        check_eq("first_iaddr", iaddr,        32'h0);
        check_eq("first_ce",    {31'b0, ce},  32'h0);

        step;
        check_eq("s0_pc",    pc,          32'h0);
        check_eq("s0_ce",    {31'b0, ce}, 32'h1);
        check_eq("s0_inst",  inst_out,    32'h0050_0093);
        check_eq("s0_iaddr", iaddr,       32'h4);
        inst_in = 32'h00A0_0113;
        step;
        check_eq("s1_pc",   pc,          32'h4);
        check_eq("s1_ce",   {31'b0, ce}, 32'h1);
        check_eq("s1_inst", inst_out,    32'h00A0_0113);

        // Three-cycle stall with the 0x8 ack landing in the first stalled cycle.
        stall   = 5'b00100;
        inst_in = 32'h00F0_0193;
        #1;
        check_eq("stall_comb", {31'b0, stall_out}, 32'h1);
        step;
        ack = 1'b0;
        check_eq("stall_pc",  pc,           32'h4);
        check_eq("stall_ce",  {31'b0, ce},  32'h1);
        check_eq("stall_stb", {31'b0, stb}, 32'h0);
        step;
        step;
        check_eq("stall3_pc", pc,          32'h4);
        check_eq("stall3_ce", {31'b0, ce}, 32'h1);
        stall = 5'b0;
        #1;
        check_eq("unstall_comb", {31'b0, stall_out}, 32'h0);
        step;
`ifdef FETCH_SKID_BUFFER_EN
        check_eq("skid_pc",    pc,           32'h8);
        check_eq("skid_ce",    {31'b0, ce},  32'h1);
        check_eq("skid_inst",  inst_out,     32'h00F0_0193);
        check_eq("skid_iaddr", iaddr,        32'hC);
        check_eq("skid_stb",   {31'b0, stb}, 32'h1);
`else
        check_eq("refetch_iaddr", iaddr,        32'h8);
        check_eq("refetch_stb",   {31'b0, stb}, 32'h1);
        check_eq("refetch_ce",    {31'b0, ce},  32'h0);
        ack = 1'b1;
        step;
        check_eq("refetch_pc",    pc,          32'h8);
        check_eq("refetch_ce1",   {31'b0, ce}, 32'h1);
        check_eq("refetch_next",  iaddr,       32'hC);
`endif

        ack     = 1'b1;
        inst_in = 32'h0000_0213;
        step;
        check_eq("c_pc",    pc,    32'hC);
        check_eq("c_iaddr", iaddr, 32'h10);

        // Redirect while 0x10 is outstanding and unacked.
        ack       = 1'b0;
        change_pc = 1'b1;
        new_pc    = 32'h100;
        step;
        change_pc = 1'b0;
        check_eq("disc_ce",    {31'b0, ce},  32'h0);
        check_eq("disc_iaddr", iaddr,        32'h10);
        check_eq("disc_stb",   {31'b0, stb}, 32'h1);
        step;
        check_eq("disc_hold", iaddr, 32'h10);
        ack     = 1'b1;
        inst_in = 32'hDEAD_BEEF;
        step;
        check_eq("disc_tgt",    iaddr,       32'h100);
        check_eq("disc_ce2",    {31'b0, ce}, 32'h0);
        check_eq("disc_pc_old", pc,          32'hC);
        inst_in = 32'h1111_1111;
        step;
        check_eq("tgt_pc",    pc,          32'h100);
        check_eq("tgt_inst",  inst_out,    32'h1111_1111);
        check_eq("tgt_ce",    {31'b0, ce}, 32'h1);
        check_eq("tgt_iaddr", iaddr,       32'h104);

        // Redirect coinciding with an ack: data dropped, target word-aligned.
        change_pc = 1'b1;
        new_pc    = 32'h203;
        inst_in   = 32'h2222_2222;
        step;
        check_eq("rdack_iaddr", iaddr,       32'h200);
        check_eq("rdack_ce",    {31'b0, ce}, 32'h0);
        check_eq("rdack_pc",    pc,          32'h100);

        // Address wrap from the top of the space.
        new_pc = 32'hFFFF_FFFC;
        step;
        change_pc = 1'b0;
        check_eq("wrap_top", iaddr, 32'hFFFF_FFFC);
        inst_in = 32'h3333_3333;
        step;
        check_eq("wrap_pc",    pc,          32'hFFFF_FFFC);
        check_eq("wrap_ce",    {31'b0, ce}, 32'h1);
        check_eq("wrap_iaddr", iaddr,       32'h0);

        // Flush kills output and keeps the address.
        flush   = 1'b1;
        inst_in = 32'h4444_4444;
        step;
        flush = 1'b0;
        check_eq("flush_ce",    {31'b0, ce}, 32'h0);
        check_eq("flush_iaddr", iaddr,       32'h0);
        check_eq("flush_pc",    pc,          32'hFFFF_FFFC);

        // Enter DISCARD, then reset asynchronously between clock edges.
        ack       = 1'b0;
        change_pc = 1'b1;
        new_pc    = 32'h300;
        step;
        change_pc = 1'b0;
        check_eq("pre_rst_iaddr", iaddr, 32'h0);
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        step;
        rst = 1'b0;
        ack = 1'b1;
        step;
        check_eq("rel_stb",   {31'b0, stb}, 32'h1);
        check_eq("rel_iaddr", iaddr,        32'h0);
        check_eq("rel_ce",    {31'b0, ce},  32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
